result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/matrix_pkg.sv | 18 +
 rtl/result_reader_if.sv | 29 ++
 rtl/result_fifo.sv | 48 ++++
 rtl/result_reader.sv | 143 ++++++++++++++
 tb/tb_result_reader.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix result path: reader FSM states, opcodes
// and the header word layout.
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rr_state_e;

  localparam logic [3:0] OP_READ_RESULT = 4'h6;

  function automatic logic [15:0] header_word(input logic [3:0] op, input logic [7:0] len);
    return {op, 4'h0, len};
  endfunction

endpackage

// File: rtl/result_reader_if.sv
// Command, memory-read and transmit-stream signals of the result reader.
// master is the reader side, slave is the SPI/memory environment side.
interface result_reader_if #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 16
);
  logic                 cmd_valid;
  logic [WORD_SIZE-1:0] cmd_data;
  logic [ADDR_SIZE-1:0] result_base;
  logic [7:0]           result_len;
  logic                 mem_r_en;
  logic [ADDR_SIZE-1:0] mem_r_addr;
  logic [WORD_SIZE-1:0] mem_r_data;
  logic                 tx_valid;
  logic [WORD_SIZE-1:0] tx_data;
  logic                 tx_ready;
  logic                 busy;
  logic                 done;

  modport master (
    input  cmd_valid, cmd_data, result_base, result_len, mem_r_data, tx_ready,
    output mem_r_en, mem_r_addr, tx_valid, tx_data, busy, done
  );

  modport slave (
    output cmd_valid, cmd_data, result_base, result_len, mem_r_data, tx_ready,
    input  mem_r_en, mem_r_addr, tx_valid, tx_data, busy, done
  );
endinterface

// File: rtl/result_fifo.sv
// Synchronous FIFO with push, pop, full, empty and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/result_reader.sv
// Reads result_len words from memory starting at result_base and streams them
// to the SPI transmitter. Define RESULT_READER_HEADER_EN to prefix a header word.
module result_reader
  import matrix_pkg::*;
#(
  parameter int         ADDR_SIZE   = 10,
  parameter int         WORD_SIZE   = 16,
  parameter logic [3:0] READ_RESULT = OP_READ_RESULT,
  parameter int         FIFO_DEPTH  = 4
) (
  input logic             clk,
  input logic             reset,
  result_reader_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  rr_state_e            state;
  logic [1:0]           cmd_sr;
  logic                 cmd_edge;
  logic                 accept;
  logic [ADDR_SIZE-1:0] base_q;
  logic [7:0]           len_q;
  logic [7:0]           idx_q;
  logic                 rd_vld_p1;
  logic                 hdr_push_p1;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WORD_SIZE-1:0] fifo_head;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [WORD_SIZE-1:0] push_data;
  logic [OW-1:0]        occupancy;
  logic                 room;
  logic                 fetch_fire;
  logic                 pipe_idle;

  assign cmd_edge = cmd_sr[0] & ~cmd_sr[1];
  assign accept   = (state == ST_IDLE) && cmd_edge && (bus.cmd_data[15:12] == READ_RESULT);

  // Buffered words plus every read or header still on its way into the FIFO.
  assign occupancy  = OW'(fifo_count) + OW'(bus.mem_r_en) + OW'(rd_vld_p1) + OW'(hdr_push_p1);
  assign room       = !fifo_full && (occupancy < OW'(FIFO_DEPTH));
  assign fetch_fire = (state == ST_FETCH) && room;
  assign pipe_idle  = !bus.mem_r_en && !rd_vld_p1 && !hdr_push_p1;

`ifdef RESULT_READER_HEADER_EN
  always_ff @(posedge clk) begin
    if (reset) hdr_push_p1 <= 1'b0;
    else       hdr_push_p1 <= accept;
  end
`else
  assign hdr_push_p1 = 1'b0;
`endif

  assign fifo_push = rd_vld_p1 | hdr_push_p1;
  assign push_data = hdr_push_p1 ? WORD_SIZE'(header_word(READ_RESULT, len_q)) : bus.mem_r_data;
  assign fifo_pop  = bus.tx_ready && !fifo_empty;

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_empty ? '0 : fifo_head;

  // Transfer parameters are captured once; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q <= bus.result_base;
      len_q  <= bus.result_len;
      idx_q  <= '0;
    end else if (fetch_fire) begin
      idx_q  <= idx_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cmd_sr         <= '0;
      rd_vld_p1      <= 1'b0;
      bus.mem_r_en   <= 1'b0;
      bus.mem_r_addr <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      cmd_sr       <= {cmd_sr[0], bus.cmd_valid};
      // Stage p1: read data returns one cycle after the strobe.
      rd_vld_p1    <= bus.mem_r_en;
      bus.mem_r_en <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.result_len != 8'd0) begin
              state    <= ST_FETCH;
              bus.busy <= 1'b1;
            end else begin
`ifdef RESULT_READER_HEADER_EN
              state    <= ST_DRAIN;
              bus.busy <= 1'b1;
`else
              state    <= ST_DONE;
              bus.done <= 1'b1;
`endif
            end
          end
        end
        ST_FETCH: begin
          if (fetch_fire) begin
            bus.mem_r_en   <= 1'b1;
            bus.mem_r_addr <= base_q + ADDR_SIZE'(idx_q);
            if (idx_q == len_q - 8'd1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty && pipe_idle) begin
            state    <= ST_DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  result_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: a transaction-level model predicts the
// read addresses and transmitted words; one negedge process compares them.
module tb_result_reader;
  import matrix_pkg::*;

  localparam int AW    = 10;
  localparam int WW    = 16;
  localparam int DEPTH = 4;
`ifdef RESULT_READER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_reader_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) bus ();

  result_reader #(
    .ADDR_SIZE   (AW),
    .WORD_SIZE   (WW),
    .READ_RESULT (4'h6),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [WW-1:0] mem [1024];

  always @(posedge clk) bus.mem_r_data <= bus.mem_r_en ? mem[bus.mem_r_addr] : 16'hDEAD;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Requests from the stimulus to the model (written only by the stimulus).
  logic [AW-1:0] m_base;
  logic [7:0]    m_len;
  int            go_seq  = 0;
  int            clr_seq = 0;

  // Model state (written only by the compare process).
  int            go_seen  = 0;
  int            clr_seen = 0;
  logic [WW-1:0] exp_w [$];
  logic [AW-1:0] exp_a [$];
  int            rd_cnt   = 0;
  int            acc_cnt  = 0;
  int            done_cnt = 0;
  int            hdr_n    = 0;
  logic          stall_prev = 1'b0;
  logic [WW-1:0] held;
  logic [WW-1:0] got_w [8];
  logic [AW-1:0] got_a [8];

  always @(negedge clk) begin
    if (clr_seq != clr_seen || go_seq != go_seen) begin
      exp_w.delete();
      exp_a.delete();
      rd_cnt = 0; acc_cnt = 0; done_cnt = 0; hdr_n = 0; stall_prev = 1'b0;
      for (int i = 0; i < 8; i++) begin got_w[i] = 16'hFFFF; got_a[i] = '1; end
      if (go_seq != go_seen) begin
        hdr_n = HDR;
        if (HDR != 0) exp_w.push_back({OP_READ_RESULT, 4'h0, m_len});
        for (int i = 0; i < int'(m_len); i++) begin
          exp_a.push_back(AW'((int'(m_base) + i) % 1024));
          exp_w.push_back(mem[AW'((int'(m_base) + i) % 1024)]);
        end
      end
      clr_seen = clr_seq;
      go_seen  = go_seq;
    end
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.done) begin
        done_cnt++;
        chk("done_busy_low", bus.busy, 0);
      end
      if (stall_prev) begin
        chk("stall_valid_held", bus.tx_valid, 1);
        chk("stall_data_held", bus.tx_data, held);
      end
      if (bus.mem_r_en) begin
        chk("outstanding_limit", (rd_cnt + 1 + hdr_n - acc_cnt) <= DEPTH, 1);
        chk("read_expected", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) chk("read_addr", bus.mem_r_addr, exp_a.pop_front());
        if (rd_cnt < 8) got_a[rd_cnt] = bus.mem_r_addr;
        rd_cnt++;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        chk("tx_expected", exp_w.size() > 0, 1);
        if (exp_w.size() > 0) chk("tx_word", bus.tx_data, exp_w.pop_front());
        if (acc_cnt < 8) got_w[acc_cnt] = bus.tx_data;
        acc_cnt++;
      end
      stall_prev = bus.tx_valid && !bus.tx_ready;
      held       = bus.tx_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_r_en"},   bus.mem_r_en,   0);
    chk({tag, "_mem_r_addr"}, bus.mem_r_addr, 0);
    chk({tag, "_tx_valid"},   bus.tx_valid,   0);
    chk({tag, "_tx_data"},    bus.tx_data,    0);
    chk({tag, "_busy"},       bus.busy,       0);
    chk({tag, "_done"},       bus.done,       0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] base,
                       input logic [7:0] len, input bit model);
    bus.result_base = base;
    bus.result_len  = len;
    bus.cmd_data    = {op, 12'h0AB};
    if (model) begin
      m_base = base;
      m_len  = len;
      go_seq++;
    end
    bus.cmd_valid = 1'b1;
    tick;
    if (model) chk("busy_before_accept", bus.busy, 0);
    tick;
    if (model && (len != 0 || HDR != 0)) chk("busy_after_accept", bus.busy, 1);
    tick;
    tick;
    bus.cmd_valid   = 1'b0;
    bus.result_base = ~base;
    bus.result_len  = len + 8'd3;
    tick;
  endtask

  task automatic wait_done(input int limit, input bit toggle);
    for (int i = 0; i < limit && done_cnt == 0; i++) begin
      if (toggle) bus.tx_ready = i[0];
      tick;
    end
    bus.tx_ready = 1'b1;
    chk("done_seen", done_cnt > 0, 1);
    repeat (3) tick;
    chk("done_once", done_cnt, 1);
    chk("busy_after_done", bus.busy, 0);
    chk("words_left", exp_w.size(), 0);
    chk("reads_left", exp_a.size(), 0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_data    = '0;
    bus.result_base = '0;
    bus.result_len  = '0;
    bus.tx_ready    = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = WW'(i * 16'h0101) ^ 16'h5A5A;
    for (int i = 0; i < 4; i++) mem[16 + i] = WW'(16'h00A0 + i);
    repeat (3) tick;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick;

    // Straight 4-word read with the transmitter always ready.
    issue(4'h6, 10'h010, 8'd4, 1);
    wait_done(100, 0);
    chk("t1_first_word", got_w[HDR], 16'h00A0);
    chk("t1_last_word", got_w[HDR + 3], 16'h00A3);
    chk("t1_first_addr", got_a[0], 10'h010);

    // Transmitter back-pressure for 10 cycles.
    bus.tx_ready = 1'b0;
    issue(4'h6, 10'h100, 8'd8, 1);
    repeat (5) tick;
    chk("t2_nothing_sent", acc_cnt, 0);
    chk("t2_valid_waiting", bus.tx_valid, 1);
    chk("t2_reads_capped", rd_cnt + HDR <= DEPTH, 1);
    bus.tx_ready = 1'b1;
    wait_done(200, 0);
    chk("t2_word_count", acc_cnt, 8 + HDR);

    // Alternating ready exercises push/pop overlap and data hold.
    issue(4'h6, 10'h200, 8'd5, 1);
    wait_done(200, 1);
    chk("t2b_word_count", acc_cnt, 5 + HDR);

    // Address wrap past the top of memory.
    issue(4'h6, 10'h3FE, 8'd3, 1);
    wait_done(100, 0);
    chk("t3_addr0", got_a[0], 10'h3FE);
    chk("t3_addr1", got_a[1], 10'h3FF);
    chk("t3_addr2", got_a[2], 10'h000);

    // Wrong opcode, then a second edge while busy.
    clr_seq++;
    issue(4'h4, 10'h050, 8'd4, 0);
    repeat (15) tick;
    chk("t4_no_reads", rd_cnt, 0);
    chk("t4_no_words", acc_cnt, 0);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_not_busy", bus.busy, 0);
    bus.tx_ready = 1'b0;
    issue(4'h6, 10'h060, 8'd6, 1);
    issue(4'h6, 10'h070, 8'd6, 0);
    chk("t4_still_busy", bus.busy, 1);
    bus.tx_ready = 1'b1;
    wait_done(200, 0);
    repeat (20) tick;
    chk("t4_single_done", done_cnt, 1);
    chk("t4_word_count", acc_cnt, 6 + HDR);
    chk("t4_read_count", rd_cnt, 6);

    // Zero-length transfer.
    issue(4'h6, 10'h123, 8'd0, 1);
    wait_done(50, 0);
    chk("t5_word_count", acc_cnt, HDR);
    chk("t5_no_reads", rd_cnt, 0);
`ifdef RESULT_READER_HEADER_EN
    chk("t5_header", got_w[0], 16'h6000);
`endif

    // Reset in the middle of a transfer after two words.
    bus.tx_ready = 1'b0;
    issue(4'h6, 10'h300, 8'd6, 1);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 50 && acc_cnt < 2; i++) tick;
    chk("t6_two_sent", acc_cnt, 2);
    reset        = 1'b1;
    bus.tx_ready = 1'b0;
    tick;
    check_reset_outputs("midreset");
    reset = 1'b0;
    clr_seq++;
    repeat (6) tick;
    chk("t6_no_done", done_cnt, 0);
    chk("t6_no_valid", bus.tx_valid, 0);
    chk("t6_no_reads", rd_cnt, 0);
    bus.tx_ready = 1'b1;
    issue(4'h6, 10'h010, 8'd4, 1);
    wait_done(100, 0);
    chk("t6_rerun_first", got_w[HDR], 16'h00A0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
